// File: rtl/sample_fetcher.sv
// rtl/sample_fetcher.sv - loops a sample window out of SDRAM into a show-ahead buffer
// Pipelined reads are issued only while buffered plus in-flight samples fit in FIFO_DEPTH.
module sample_fetcher #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 26
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       length,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              sdram_chipselect,
  output logic [1:0]        sdram_byteenable_n,
  output logic              sdram_read_n,
  output logic              sdram_write_n,
  output logic [15:0]       sdram_writedata,
  input  logic [15:0]       sdram_readdata,
  input  logic              sdram_readdata_valid,
  input  logic              sdram_waitrequest,
  output logic [15:0]       sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              wrap_pulse
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [31:0]       len_q, len_d, index_q, index_d;
  logic [CW-1:0]     outst_q, outst_d, count_q, count_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              read_n_q, read_n_d;
  logic [15:0]       mem_q [FIFO_DEPTH];
  logic              accepted, returned, push, pop, last_index;
  logic [CW:0]       credit_sum;

  assign accepted   = !read_n_q && !sdram_waitrequest;
  // Stray readdata_valid with nothing in flight (e.g. after reset) is ignored.
  assign returned   = sdram_readdata_valid && (outst_q != '0);
  assign push       = returned && (state_q == FETCH);
  assign pop        = sample_valid && sample_ready;
  assign last_index = (index_q + 32'd1) == len_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    index_d    = index_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    read_n_d   = 1'b1;
    outst_d    = outst_q + CW'(accepted) - CW'(returned);
    count_d    = count_q + CW'(push) - CW'(pop);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (accepted && state_q == FETCH) index_d = last_index ? 32'd0 : index_q + 32'd1;

    unique case (state_q)
      IDLE: begin
        if (start && length != 32'd0) begin
          state_d  = FETCH;
          base_d   = base_addr;
          len_d    = length;
          index_d  = 32'd0;
          count_d  = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end
      end
      FETCH: begin
        if (!start) begin
          state_d  = FLUSH;
          count_d  = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end
      end
      FLUSH: begin
        if (outst_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A stalled request is held; otherwise a new one needs a free slot for its data.
    credit_sum = {1'b0, count_d} + {1'b0, outst_d};
    if (state_d == FETCH) begin
      if (!read_n_q && sdram_waitrequest) read_n_d = 1'b0;
      else if (credit_sum < DEPTH_C)      read_n_d = 1'b0;
    end
    addr_d = base_d + ADDR_W'(index_d);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      index_q  <= '0;
      addr_q   <= '0;
      outst_q  <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      read_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      index_q  <= index_d;
      addr_q   <= addr_d;
      outst_q  <= outst_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      read_n_q <= read_n_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= sdram_readdata;
  end

  assign sdram_addr         = addr_q;
  assign sdram_read_n       = read_n_q;
  assign sdram_chipselect   = 1'b1;
  assign sdram_byteenable_n = 2'b00;
  assign sdram_write_n      = 1'b1;
  assign sdram_writedata    = 16'h0000;
  assign sample_data        = mem_q[rd_ptr_q];
  assign sample_valid       = (state_q == FETCH) && (count_q != '0);
  assign busy               = (state_q != IDLE);
  assign wrap_pulse         = accepted && (state_q == FETCH) && last_index;

endmodule

// File: tb/tb_sample_fetcher.sv
// tb/tb_sample_fetcher.sv - directed vector bench for sample_fetcher
// SDRAM model returns word data = addr[15:0]^16'h5A5A a fixed latency after acceptance.
module tb_sample_fetcher;
  localparam int DEPTH = 16;
  localparam int AW    = 26;
  localparam int LAT   = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [31:0]   length;
  logic [AW-1:0] sdram_addr;
  logic          sdram_chipselect;
  logic [1:0]    sdram_byteenable_n;
  logic          sdram_read_n;
  logic          sdram_write_n;
  logic [15:0]   sdram_writedata;
  logic [15:0]   sdram_readdata = 16'h0;
  logic          sdram_readdata_valid = 1'b0;
  logic          sdram_waitrequest;
  logic [15:0]   sample_data;
  logic          sample_valid;
  logic          sample_ready;
  logic          busy;
  logic          wrap_pulse;

  always #5 clock = ~clock;

  sample_fetcher #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
    .sdram_addr(sdram_addr), .sdram_chipselect(sdram_chipselect),
    .sdram_byteenable_n(sdram_byteenable_n), .sdram_read_n(sdram_read_n),
    .sdram_write_n(sdram_write_n), .sdram_writedata(sdram_writedata),
    .sdram_readdata(sdram_readdata), .sdram_readdata_valid(sdram_readdata_valid),
    .sdram_waitrequest(sdram_waitrequest), .sample_data(sample_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .busy(busy),
    .wrap_pulse(wrap_pulse)
  );

  typedef struct {
    logic [AW-1:0]      base;
    int                 len;
    int                 rdy_mod;
    int                 wt_mod;
    logic [5:0][AW-1:0] ea;
  } vec_t;

  int            n_cmp = 0;
  int            n_fail = 0;
  int            accepts = 0;
  int            wraps = 0;
  int            returns = 0;
  int            hold_viol = 0;
  longint        cyc = 0;
  bit            hold_ret = 1'b0;
  logic [15:0]   q_dat[$];
  longint        q_due[$];
  logic [15:0]   got[$];
  logic          pend_prev = 1'b0;
  logic          start_prev = 1'b0;
  logic [AW-1:0] addr_prev = '0;

  function automatic logic [15:0] dat(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic vec_t mk(input logic [AW-1:0] b, input int l, input int rm, input int wm,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                              input logic [AW-1:0] a4, input logic [AW-1:0] a5);
    vec_t v;
    v.base = b; v.len = l; v.rdy_mod = rm; v.wt_mod = wm;
    v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3; v.ea[4] = a4; v.ea[5] = a5;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // SDRAM slave model, stall-stability monitor and sample sink, all on the falling edge.
  always @(negedge clock) begin
    cyc++;
    if (pend_prev && start_prev && reset_n && (sdram_read_n || sdram_addr != addr_prev))
      hold_viol++;
    pend_prev  = reset_n && !sdram_read_n && sdram_waitrequest;
    addr_prev  = sdram_addr;
    start_prev = start;
    sdram_readdata_valid = 1'b0;
    if (!hold_ret && q_due.size() > 0 && q_due[0] <= cyc) begin
      sdram_readdata_valid = 1'b1;
      sdram_readdata = q_dat.pop_front();
      void'(q_due.pop_front());
      returns++;
    end
    if (reset_n && !sdram_read_n && !sdram_waitrequest) begin
      accepts++;
      q_dat.push_back(dat(sdram_addr));
      q_due.push_back(cyc + LAT);
    end
    if (wrap_pulse) wraps++;
    if (sample_valid && sample_ready) got.push_back(sample_data);
  end

  task automatic wait_idle(input string nm);
    for (int c = 0; c < 200 && busy; c++) tick();
    chk(nm, busy, 0);
  endtask

  vec_t vt[5];
  int   acc0, wr0, ret0, viol;
  logic [AW-1:0] ea;

  initial begin
    vt[0] = mk(26'h100, 4, 1, 0, 26'h100, 26'h101, 26'h102, 26'h103, 26'h100, 26'h101);
    vt[1] = mk(26'h3FFFFFE, 3, 1, 0, 26'h3FFFFFE, 26'h3FFFFFF, 26'h0, 26'h3FFFFFE, 26'h3FFFFFF, 26'h0);
    vt[2] = mk(26'h2000, 1, 1, 0, 26'h2000, 26'h2000, 26'h2000, 26'h2000, 26'h2000, 26'h2000);
    vt[3] = mk(26'h40, 20, 3, 2, 26'h40, 26'h41, 26'h42, 26'h43, 26'h44, 26'h45);
    vt[4] = mk(26'h500, 17, 1, 0, 26'h500, 26'h501, 26'h502, 26'h503, 26'h504, 26'h505);

    reset_n = 1'b0; start = 1'b0; base_addr = '0; length = 32'd0;
    sdram_waitrequest = 1'b0; sample_ready = 1'b0;
    repeat (3) tick();
    chk("rst_read_n", sdram_read_n, 1);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_wrap", wrap_pulse, 0);
    chk("const_cs", sdram_chipselect, 1);
    chk("const_be_n", sdram_byteenable_n, 0);
    chk("const_write_n", sdram_write_n, 1);
    chk("const_wdata", sdram_writedata, 0);
    reset_n = 1'b1;
    tick();

    // Zero length never leaves IDLE.
    acc0 = accepts; base_addr = 26'h100; length = 32'd0; start = 1'b1;
    repeat (10) tick();
    chk("len0_busy", busy, 0);
    chk("len0_read_n", sdram_read_n, 1);
    chk("len0_accepts", accepts - acc0, 0);
    start = 1'b0;
    tick();

    // First read stalled 5 cycles, then a starved consumer fills the buffer exactly.
    acc0 = accepts; base_addr = 26'h100; length = 32'd4;
    sdram_waitrequest = 1'b1; sample_ready = 1'b0; start = 1'b1;
    for (int c = 0; c < 10 && sdram_read_n; c++) tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_addr_%0d", i), sdram_addr, 26'h100);
      chk($sformatf("stall_read_n_%0d", i), sdram_read_n, 0);
      tick();
    end
    chk("stall_accepts", accepts - acc0, 0);
    sdram_waitrequest = 1'b0;
    tick();
    chk("stall_one_read", accepts - acc0, 1);
    repeat (100) tick();
    chk("full_accepts", accepts - acc0, DEPTH);
    chk("full_read_n", sdram_read_n, 1);
    got.delete();
    sample_ready = 1'b1;
    for (int c = 0; c < 500 && got.size() < 40; c++) tick();
    chk("full_count", got.size() >= 40, 1);
    for (int n = 0; n < 40 && n < got.size(); n++) begin
      ea = 26'h100 + AW'(n % 4);
      chk($sformatf("full_s%0d", n), got[n], dat(ea));
    end
    sample_ready = 1'b0; start = 1'b0;
    wait_idle("full_idle");

    // Stop with 3 reads in flight; the 4th, stalled, request is withdrawn.
    hold_ret = 1'b1; acc0 = accepts; base_addr = 26'h300; length = 32'd8; start = 1'b1;
    for (int c = 0; c < 20 && accepts - acc0 < 3; c++) tick();
    sdram_waitrequest = 1'b1; start = 1'b0;
    viol = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!busy || sample_valid || !sdram_read_n) viol++;
    end
    chk("flush_hold_state", viol, 0);
    chk("flush_accepts", accepts - acc0, 3);
    ret0 = returns; hold_ret = 1'b0; sdram_waitrequest = 1'b0;
    viol = 0;
    for (int c = 0; c < 50 && busy; c++) begin
      tick();
      if (sample_valid || (returns - ret0 < 3 && !busy)) viol++;
    end
    chk("flush_drain", viol, 0);
    chk("flush_idle", busy, 0);

    // Reset with 2 reads in flight; their late data must not reach the buffer.
    hold_ret = 1'b1; acc0 = accepts; base_addr = 26'h200; length = 32'd8; start = 1'b1;
    for (int c = 0; c < 20 && accepts - acc0 < 2; c++) tick();
    sdram_waitrequest = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("mrst_read_n", sdram_read_n, 1);
    chk("mrst_addr", sdram_addr, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", sample_valid, 0);
    chk("mrst_wrap", wrap_pulse, 0);
    start = 1'b0;
    tick();
    reset_n = 1'b1; sdram_waitrequest = 1'b0; hold_ret = 1'b0; ret0 = returns;
    for (int c = 0; c < 20 && returns - ret0 < 2; c++) tick();
    repeat (3) tick();
    chk("late_valid", sample_valid, 0);
    chk("late_busy", busy, 0);

    // Streaming vectors: ordering, modular address wrap, wrap_pulse rate.
    for (int v = 0; v < 5; v++) begin
      got.delete(); acc0 = accepts; wr0 = wraps;
      base_addr = vt[v].base; length = 32'(vt[v].len); sample_ready = 1'b0; start = 1'b1;
      for (int c = 0; c < 3000 && got.size() < 40; c++) begin
        tick();
        sample_ready = (c % vt[v].rdy_mod) == 0;
        sdram_waitrequest = (vt[v].wt_mod != 0) && ((c % vt[v].wt_mod) == 0);
      end
      sample_ready = 1'b0; sdram_waitrequest = 1'b0; start = 1'b0;
      chk($sformatf("v%0d_count", v), got.size() >= 40, 1);
      for (int n = 0; n < 40 && n < got.size(); n++) begin
        ea = (n < 6) ? vt[v].ea[n] : vt[v].base + AW'(n % vt[v].len);
        chk($sformatf("v%0d_s%0d", v, n), got[n], dat(ea));
      end
      wait_idle($sformatf("v%0d_idle", v));
      chk($sformatf("v%0d_valid_off", v), sample_valid, 0);
      chk($sformatf("v%0d_wraps", v), wraps - wr0, (accepts - acc0) / vt[v].len);
    end

    chk("hold_stable", hold_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
